// File: rtl/countdown51bit_pkg.sv
// countdown51bit_pkg
// Shared types and constants for the loadable 51-bit down-counter/timer.
//   state_t                    : controller states (IDLE, RUN, PAUSED)
//   COUNTDOWN51_WIDTH_DEFAULT  : default counter/load width in bits
package countdown51bit_pkg;

  localparam int COUNTDOWN51_WIDTH_DEFAULT = 51;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

endpackage : countdown51bit_pkg

// File: rtl/countdown51bit_if.sv
// countdown51bit_if
// Host-side bundle of the down-counter: load handshake, run controls and
// status outputs.
//   load_valid / load_value / load_ready : load handshake (host -> block)
//   pause / abort                        : run controls from the host
//   count / busy / done                  : block status back to the host
// Modports:
//   master : the host driving loads and controls
//   slave  : the counter block
interface countdown51bit_if
  import countdown51bit_pkg::*;
#(
  parameter int WIDTH = COUNTDOWN51_WIDTH_DEFAULT
);

  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load_valid,
    output load_value,
    output pause,
    output abort,
    input  load_ready,
    input  count,
    input  busy,
    input  done
  );

  modport slave (
    input  load_valid,
    input  load_value,
    input  pause,
    input  abort,
    output load_ready,
    output count,
    output busy,
    output done
  );

endinterface : countdown51bit_if

// File: rtl/countdown51bit_fsm.sv
// countdown51bit_fsm
// State register and priority logic (reset > abort > pause > decrement) of
// the down-counter. Produces the datapath strobes and the registered
// busy/done status.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   load_valid     : host presents a load value
//   load_zero      : presented load value is zero
//   pause, abort   : host run controls
//   count_is_one   : current count equals 1 (terminal step)
//   load_ready     : combinational, high in IDLE only
//   busy, done     : registered status
//   load_en        : count takes load_value this edge
//   clr_en         : count clears this edge (abort while active)
//   dec_en         : count decrements this edge
//   reload_en      : count reloads from the reload register this edge
//                    (only with COUNTDOWN51BIT_AUTORELOAD_EN)
// Configuration macro: COUNTDOWN51BIT_AUTORELOAD_EN
//
// state  | meaning
// IDLE   | waiting for a load, load_ready high, count holds
// RUN    | decrementing once per cycle
// PAUSED | frozen by pause, count holds; leaving costs one bubble cycle
module countdown51bit_fsm
  import countdown51bit_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load_valid,
  input  logic load_zero,
  input  logic pause,
  input  logic abort,
  input  logic count_is_one,
  output logic load_ready,
  output logic busy,
  output logic done,
  output logic load_en,
  output logic clr_en,
`ifdef COUNTDOWN51BIT_AUTORELOAD_EN
  output logic reload_en,
`endif
  output logic dec_en
);

  state_t state;
  logic   run_step;

  always_comb begin
    run_step   = (state == RUN) && !abort && !pause;
    load_ready = (state == IDLE);
    load_en    = load_ready && load_valid;
    clr_en     = (state != IDLE) && abort;
`ifdef COUNTDOWN51BIT_AUTORELOAD_EN
    // The terminal step reloads instead of reaching zero.
    reload_en  = run_step && count_is_one;
    dec_en     = run_step && !count_is_one;
`else
    dec_en     = run_step;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_en) begin
            if (load_zero) begin
              // A zero load completes immediately without leaving IDLE.
              done <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (pause) begin
            state <= PAUSED;
          end else if (count_is_one) begin
            done <= 1'b1;
`ifndef COUNTDOWN51BIT_AUTORELOAD_EN
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end
        end
        PAUSED: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!pause) begin
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : countdown51bit_fsm

// File: rtl/countdown51bit.sv
// countdown51bit
// Loadable down-counter/timer. A host loads a terminal count through a
// valid/ready handshake; the block decrements once per enabled cycle and
// pulses done for one cycle when the count reaches zero.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : countdown51bit_if.slave (load handshake, pause/abort, count,
//           busy, done)
// Configuration macro: COUNTDOWN51BIT_AUTORELOAD_EN
//   defined   : the last accepted load value is kept and reloaded at each
//               terminal step, making the count periodic until abort/reset
//   undefined : one-shot count, no reload register
module countdown51bit
  import countdown51bit_pkg::*;
#(
  parameter int WIDTH = COUNTDOWN51_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  countdown51bit_if.slave    bus
);

  logic [WIDTH-1:0] count_q;
  logic             count_is_one;
  logic             load_zero;
  logic             load_en;
  logic             clr_en;
  logic             dec_en;
  logic             busy;
  logic             done;
  logic             load_ready;
`ifdef COUNTDOWN51BIT_AUTORELOAD_EN
  logic             reload_en;
  logic [WIDTH-1:0] reload_q;
`endif

  assign count_is_one = (count_q == WIDTH'(1));
  assign load_zero    = (bus.load_value == '0);

  countdown51bit_fsm u_fsm (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (bus.load_valid),
    .load_zero    (load_zero),
    .pause        (bus.pause),
    .abort        (bus.abort),
    .count_is_one (count_is_one),
    .load_ready   (load_ready),
    .busy         (busy),
    .done         (done),
    .load_en      (load_en),
    .clr_en       (clr_en),
`ifdef COUNTDOWN51BIT_AUTORELOAD_EN
    .reload_en    (reload_en),
`endif
    .dec_en       (dec_en)
  );

`ifdef COUNTDOWN51BIT_AUTORELOAD_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      reload_q <= '0;
    end else if (load_en) begin
      reload_q <= bus.load_value;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr_en) begin
      count_q <= '0;
    end else if (load_en) begin
      count_q <= bus.load_value;
`ifdef COUNTDOWN51BIT_AUTORELOAD_EN
    end else if (reload_en) begin
      count_q <= reload_q;
`endif
    end else if (dec_en) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign bus.count      = count_q;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.load_ready = load_ready;

endmodule : countdown51bit

// File: tb/tb_countdown51bit.sv
module tb_countdown51bit;
  import countdown51bit_pkg::*;

  localparam int W = COUNTDOWN51_WIDTH_DEFAULT;
  localparam logic [W-1:0] MAXV = {W{1'b1}};

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  countdown51bit_if bus_if ();

  countdown51bit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic         lv;
    logic [W-1:0] val;
    logic         pause;
    logic         abort;
    logic [W-1:0] e_count;
    logic         e_busy;
    logic         e_done;
    logic         e_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic lv, input logic [W-1:0] val,
                              input logic p, input logic a,
                              input logic [W-1:0] ec, input logic eb,
                              input logic ed, input logic er);
    vec_t v;
    v.lv = lv; v.val = val; v.pause = p; v.abort = a;
    v.e_count = ec; v.e_busy = eb; v.e_done = ed; v.e_ready = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] ec,
                         input logic eb, input logic ed, input logic er);
    chk({tag, " count"}, bus_if.count, ec);
    chk({tag, " busy"},  W'(bus_if.busy), W'(eb));
    chk({tag, " done"},  W'(bus_if.done), W'(ed));
    chk({tag, " ready"}, W'(bus_if.load_ready), W'(er));
  endtask

  task automatic drive(input logic lv, input logic [W-1:0] val, input logic p, input logic a);
    bus_if.load_valid = lv;
    bus_if.load_value = val;
    bus_if.pause      = p;
    bus_if.abort      = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    step();
    chk_all("reset", '0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;

`ifndef COUNTDOWN51BIT_AUTORELOAD_EN
    // Load 5 and count out.
    vecs.push_back(mk(1, 5, 0, 0, 5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    // Load 0: immediate done, stays IDLE.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    // pause/abort ignored in IDLE.
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1));
    // Load 4, pause three cycles after first decrement.
    vecs.push_back(mk(1, 4, 0, 0, 4, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
    // Load 10, abort together with pause at count 6.
    vecs.push_back(mk(1, 10, 0, 0, 10, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 9, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 6, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    // Abort from PAUSED.
    vecs.push_back(mk(1, 2, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1));
    // Full-scale load.
    vecs.push_back(mk(1, MAXV, 0, 0, MAXV, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, MAXV - 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].lv, vecs[i].val, vecs[i].pause, vecs[i].abort);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_busy,
              vecs[i].e_done, vecs[i].e_ready);
    end

    // Reset asserted mid-count at 6.
    drive(1, 10, 0, 0);
    step();
    drive(0, 0, 0, 0);
    for (int j = 0; j < 4; j++) step();
    chk("rst_mid pre count", bus_if.count, 6);
    reset = 1'b1;
    step();
    chk_all("rst_mid", '0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    step();
    chk_all("rst_mid after", '0, 1'b0, 1'b0, 1'b1);

    // load_valid held with 7 while counting from 3.
    drive(1, 3, 0, 0);
    step();
    chk_all("hold acc3", 3, 1'b1, 1'b0, 1'b0);
    drive(1, 7, 0, 0);
    step();
    chk_all("hold c2", 2, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("hold c1", 1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("hold c0", 0, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("hold acc7", 7, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0, 0);
    begin
      int cyc;
      bit seen;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 20) begin
        step();
        cyc++;
        if (bus_if.done) seen = 1'b1;
        else chk($sformatf("hold run%0d count", cyc), bus_if.count, W'(7 - cyc));
      end
      chk("hold done latency", W'(cyc), 7);
      chk("hold done seen", W'(seen), 1);
    end
    chk_all("hold end", 0, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("hold pulse width", 0, 1'b0, 1'b0, 1'b1);
`else
    // Periodic reload with period 3.
    drive(1, 3, 0, 0);
    step();
    chk_all("ar acc3", 3, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      step();
      chk_all($sformatf("ar r%0d c2", r), 2, 1'b1, 1'b0, 1'b0);
      step();
      chk_all($sformatf("ar r%0d c1", r), 1, 1'b1, 1'b0, 1'b0);
      step();
      chk_all($sformatf("ar r%0d wrap", r), 3, 1'b1, 1'b1, 1'b0);
    end
    drive(0, 0, 0, 1);
    step();
    chk_all("ar abort", 0, 1'b0, 1'b0, 1'b1);
    drive(1, MAXV, 0, 0);
    step();
    chk_all("ar max", MAXV, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0, 0);
    step();
    chk_all("ar max-1", MAXV - 1, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0, 1);
    step();
    chk_all("ar abort2", 0, 1'b0, 1'b0, 1'b1);
    drive(1, 0, 0, 0);
    step();
    chk_all("ar zero", 0, 1'b0, 1'b1, 1'b1);
    drive(0, 0, 0, 0);
    step();
    chk_all("ar zero after", 0, 1'b0, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_countdown51bit

// File: doc/countdown51bit.md
# countdown51bit

Loadable 51-bit down-counter/timer. It is the consuming counterpart of the 51-bit free-running up-counter in the same digital model library. A host loads a terminal count through a valid/ready handshake. The block then decrements once per enabled cycle and emits a one-cycle `done` pulse when the count reaches zero. It sits beside the up-counter in mixed-signal ngspice co-simulation models as the interval/timeout generator.

## Interface
- `WIDTH`, 51, counter and load width in bits.
- `clk`, in, 1, rising-edge clock.
- `reset`, in, 1, synchronous, active-high; clock `clk`.
- `load_valid`, in, 1, host presents `load_value`.
- `load_value`, in, WIDTH, count to load.
- `load_ready`, out, 1, block accepts a load. Combinational: high in IDLE only.
- `pause`, in, 1, freeze counting while high.
- `abort`, in, 1, cancel the active count.
- `count`, out, WIDTH, current count (registered).
- `busy`, out, 1, high in RUN or PAUSED (registered).
- `done`, out, 1, one-cycle pulse on reaching terminal count (registered).

## Operation
- FSM states are IDLE, RUN and PAUSED.
- Reset values: state IDLE, `count`=0, `done`=0, `busy`=0. This gives `load_ready`=1 in the cycle after reset.
- Priority at each edge, highest first: reset, then abort, then pause, then decrement.
- IDLE:
  - A load is accepted at an edge where `load_valid && load_ready`. `count` takes `load_value`.
  - If `load_value`≠0, go to RUN.
  - If `load_value`=0, stay in IDLE and pulse `done` at the same edge.
  - In IDLE, `pause` and `abort` have no effect and `count` holds.
- RUN:
  - `abort`=1: go to IDLE, `count`=0, no `done`.
  - Otherwise `pause`=1: go to PAUSED; no decrement at that edge.
  - Otherwise decrement. When `count`=1, the edge sets `count`=0, `done`=1 and the next state is IDLE.
- PAUSED:
  - `abort`=1: go to IDLE, `count`=0, no `done`.
  - `pause`=0: go to RUN; no decrement at that edge (one-cycle resume bubble).
  - Otherwise hold `count`.
- `load_valid` while busy is ignored and not queued. The host must hold `load_valid` until it sees `load_ready`.
- All arithmetic is unsigned modulo 2^WIDTH. `count` never decrements below 0 because RUN exits at 1→0.
- `load_value`=2^51−1 is legal and requires no special handling.

## Timing
- Load accepted at edge k with value N>0 and no pause:
  - `count`=N after edge k.
  - `count`=N−j after edge k+j.
  - `done`=1 and `count`=0 after edge k+N.
  - `busy` falls after edge k+N.
  - `load_ready` is high in the cycle after edge k+N, so the earliest next accept is edge k+N+1.
- Each cycle spent in PAUSED, plus the resume bubble, adds exactly one cycle to the done latency.
- `done` is high for exactly one cycle per completed count.
- Reset asserted mid-count returns all outputs to reset values at that edge with no `done`.

## Configuration
- Macro: `COUNTDOWN51BIT_AUTORELOAD_EN`.
- Defined:
  - A WIDTH-bit reload register captures `load_value` on every accept.
  - In RUN, the edge that would set `count` 1→0 instead asserts `done`, loads `count` from the reload register and stays in RUN. The count is periodic with period N cycles, and `count` never reads 0 while running.
  - Only `abort` or reset returns the block to IDLE.
  - A load of 0 still pulses `done` once and stays in IDLE.
- Undefined: behaves as described in Operation (one-shot); the reload register is absent.

## Structure
- Package `countdown51bit_pkg` holds:
  - the state enum (IDLE, RUN, PAUSED);
  - `COUNTDOWN51_WIDTH_DEFAULT`=51.
- Sub-module `countdown51bit_fsm` holds the state register and next-state/priority logic. It outputs `dec_en`, `load_en` and `clr_en`.
- The top level holds the count and reload datapath and the output registers.

## Test plan
- Reset, then load 5 at edge k → `count` reads 5,4,3,2,1 after edges k…k+4. After edge k+5, `count`=0, `done`=1 for one cycle and `busy`=0.
- Load 0 → `done`=1 after the accept edge, state stays IDLE, `load_ready` stays high, `busy` never rises.
- Load 4, pause high for 3 cycles after the first decrement → `done` arrives 4 cycles late (3 paused plus 1 bubble); `count` holds at 3 while paused.
- Load 10, assert `abort` and `pause` together at count 6 → next cycle `count`=0, IDLE, no `done`. Reset asserted at count 6 behaves the same.
- Hold `load_valid` with 7 while busy counting from 3 → not accepted until `load_ready`; then accepted and runs to 7 cycles.
- With `COUNTDOWN51BIT_AUTORELOAD_EN`, load 3 → `done` every 3 cycles, `count` sequence 3,2,1,3,2,1… Load `load_value`=2^51−1 → first decrement reads 2^51−2.
